// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory access arbiter: FSM state encodings,
// owner codes and the default RAM address window.
package mem_arb_pkg;

  localparam int          WORD_LENGTH_DEF = 32;
  localparam logic [15:0] RAM_BASE_HI_DEF = 16'h1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DEV = 1'b1
  } owner_t;

  // The upper address half-word selects RAM; everything else maps to ROM.
  function automatic logic is_ram(input logic [15:0] addr_hi, input logic [15:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of requester and memory-side signals of the memory access arbiter.
// slave  : the arbiter's view.
// master : the environment's view (core, device and data memory together).
interface mem_access_arbiter_if #(
  parameter int W = 32
) ();

  logic         cpu_req;
  logic         cpu_we;
  logic [W-1:0] cpu_addr;
  logic [W-1:0] cpu_wdata;
  logic         cpu_gnt;
  logic         cpu_rvalid;

  logic         dev_req;
  logic         dev_we;
  logic [W-1:0] dev_addr;
  logic [W-1:0] dev_wdata;
  logic         dev_gnt;
  logic         dev_rvalid;

  logic [W-1:0] rdata;

  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_data;
  logic         mem_we;
  logic         mem_sel;
  logic [W-1:0] mem_q;

  logic         wr_rom_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dev_req, dev_we, dev_addr, dev_wdata,
    input  mem_q,
    output cpu_gnt, cpu_rvalid, dev_gnt, dev_rvalid, rdata,
    output mem_addr, mem_data, mem_we, mem_sel, wr_rom_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dev_req, dev_we, dev_addr, dev_wdata,
    output mem_q,
    input  cpu_gnt, cpu_rvalid, dev_gnt, dev_rvalid, rdata,
    input  mem_addr, mem_data, mem_we, mem_sel, wr_rom_err
  );

endinterface

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// Two-way combinational winner select between core and device.
// Default: round-robin, the requester that did not go last wins a tie.
// MEM_ARB_CPU_PRIORITY_EN: fixed priority, the core always wins a tie.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic   i_cpu_req,
  input  logic   i_dev_req,
  input  owner_t i_last_owner,
  output logic   o_any,
  output owner_t o_winner
);

`ifdef MEM_ARB_CPU_PRIORITY_EN
  logic w_unused_last_owner;
  assign w_unused_last_owner = i_last_owner;
`endif

  // Pick the winner among the active requests.
  // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    o_any    = i_cpu_req | i_dev_req;
    o_winner = OWN_CPU;
    if (i_cpu_req && i_dev_req) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
      o_winner = OWN_CPU;
`else
      o_winner = (i_last_owner == OWN_CPU) ? OWN_DEV : OWN_CPU;
`endif
    end else if (i_dev_req) begin
      o_winner = OWN_DEV;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one synchronous data-memory port between the core (requester 0)
// and a device (requester 1). IDLE -> ISSUE -> (RESP) sequencing, ROM/RAM
// decode from the latched address, dropped writes to ROM flagged.
// Optional macro: MEM_ARB_CPU_PRIORITY_EN selects fixed core priority
// instead of round-robin (see rr_arbiter2).
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          WORD_LENGTH = WORD_LENGTH_DEF,
  parameter logic [15:0] RAM_BASE_HI = RAM_BASE_HI_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_arbiter_if.slave bus
);

  state_t                   r_state;
  state_t                   w_next_state;
  owner_t                   r_owner;
  owner_t                   r_last_owner;
  logic                     r_we;
  logic [WORD_LENGTH-1:0]   r_addr;
  logic [WORD_LENGTH-1:0]   r_wdata;
  logic [WORD_LENGTH-1:0]   r_rdata;

  logic                     w_latch_en;
  logic                     w_any;
  owner_t                   w_winner;
  owner_t                   w_arb_last;
  logic                     w_sel;
  logic                     w_issue;

  // The access finishing in RESP counts as the most recent one for a back-to-back decision.
  assign w_arb_last = (r_state == ST_RESP) ? r_owner : r_last_owner;

  rr_arbiter2 u_arb (
    .i_cpu_req    (bus.cpu_req),
    .i_dev_req    (bus.dev_req),
    .i_last_owner (w_arb_last),
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  assign w_sel   = is_ram(r_addr[WORD_LENGTH-1 -: 16], RAM_BASE_HI);
  assign w_issue = (r_state == ST_ISSUE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and per-state handshake/memory control.
  always_comb begin
    w_next_state    = r_state;
    w_latch_en      = 1'b0;
    bus.cpu_gnt     = 1'b0;
    bus.dev_gnt     = 1'b0;
    bus.cpu_rvalid  = 1'b0;
    bus.dev_rvalid  = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_sel     = 1'b0;
    bus.wr_rom_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_latch_en   = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.cpu_gnt    = (r_owner == OWN_CPU);
        bus.dev_gnt    = (r_owner == OWN_DEV);
        bus.mem_sel    = w_sel;
        bus.mem_we     = r_we & w_sel;
        bus.wr_rom_err = r_we & ~w_sel;
        w_next_state   = r_we ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        bus.cpu_rvalid = (r_owner == OWN_CPU);
        bus.dev_rvalid = (r_owner == OWN_DEV);
        if (w_any) begin
          w_latch_en   = 1'b1;
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operation latch, ownership history and read-data capture.
  // NOTE: the op latch and read register are reset too, so the memory bus and rdata read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DEV;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      if (w_latch_en) begin
        r_owner <= w_winner;
        r_we    <= (w_winner == OWN_CPU) ? bus.cpu_we    : bus.dev_we;
        r_addr  <= (w_winner == OWN_CPU) ? bus.cpu_addr  : bus.dev_addr;
        r_wdata <= (w_winner == OWN_CPU) ? bus.cpu_wdata : bus.dev_wdata;
      end
      if (w_issue && r_we) r_last_owner <= r_owner;
      if (r_state == ST_RESP) begin
        r_rdata      <= bus.mem_q;
        r_last_owner <= r_owner;
      end
    end
  end

  // Memory q arrives during RESP; pass it through then and hold it afterwards.
  assign bus.rdata    = (r_state == ST_RESP) ? bus.mem_q : r_rdata;
  assign bus.mem_addr = r_addr;
  assign bus.mem_data = r_wdata;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_access_arbiter_if #(.W(32)) bus ();

  mem_access_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: contents are a fixed function of the address.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h1001_0004) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
  endfunction

  always @(posedge clk) bus.mem_q <= mem_model(bus.mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_cpu;
    logic [31:0] exp_addr;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dev_req = 1'b0; bus.dev_we = 1'b0; bus.dev_addr = '0; bus.dev_wdata = '0;
    step(); step();

    // Reset state
    check("rst_cpu_gnt",  bus.cpu_gnt,    0);
    check("rst_rvalid",   bus.cpu_rvalid, 0);
    check("rst_rdata",    bus.rdata,      0);
    check("rst_mem_addr", bus.mem_addr,   0);
    check("rst_mem_we",   bus.mem_we,     0);
    reset = 1'b0;

    // 1: core read from RAM
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1001_0004;
    step();
    check("t1_cpu_gnt",  bus.cpu_gnt,    1);
    check("t1_dev_gnt",  bus.dev_gnt,    0);
    check("t1_mem_sel",  bus.mem_sel,    1);
    check("t1_mem_addr", bus.mem_addr,   32'h1001_0004);
    check("t1_mem_we",   bus.mem_we,     0);
    check("t1_early_rv", bus.cpu_rvalid, 0);
    bus.cpu_req = 1'b0;
    step();
    check("t1_rvalid",   bus.cpu_rvalid, 1);
    check("t1_rdata",    bus.rdata,      32'hDEAD_BEEF);
    check("t1_gnt_off",  bus.cpu_gnt,    0);
    check("t1_sel_off",  bus.mem_sel,    0);
    step();
    check("t1_rv_off",   bus.cpu_rvalid, 0);
    check("t1_rd_hold",  bus.rdata,      32'hDEAD_BEEF);

    // 2: both requesting reads, held; reset first so the core wins the first tie
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1001_0100;
    bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_addr = 32'h1001_0200;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
      exp_cpu = 1'b1;
`else
      exp_cpu = (i % 2 == 0);
`endif
      exp_addr = exp_cpu ? 32'h1001_0100 : 32'h1001_0200;
      step();
      check($sformatf("t2_cpu_gnt%0d", i),  bus.cpu_gnt,  exp_cpu);
      check($sformatf("t2_dev_gnt%0d", i),  bus.dev_gnt,  !exp_cpu);
      check($sformatf("t2_addr%0d", i),     bus.mem_addr, exp_addr);
      step();
      check($sformatf("t2_cpu_rv%0d", i),   bus.cpu_rvalid, exp_cpu);
      check($sformatf("t2_dev_rv%0d", i),   bus.dev_rvalid, !exp_cpu);
      check($sformatf("t2_rdata%0d", i),    bus.rdata,      mem_model(exp_addr));
      if (i == 3) begin
        bus.cpu_req = 1'b0;
        bus.dev_req = 1'b0;
      end
    end
    step();
    check("t2_idle_gnt", bus.cpu_gnt | bus.dev_gnt, 0);

    // 3: device write to RAM
    bus.dev_req = 1'b1; bus.dev_we = 1'b1; bus.dev_addr = 32'h1001_0010; bus.dev_wdata = 32'h55AA_55AA;
    step();
    check("t3_dev_gnt",  bus.dev_gnt,  1);
    check("t3_mem_we",   bus.mem_we,   1);
    check("t3_mem_sel",  bus.mem_sel,  1);
    check("t3_mem_data", bus.mem_data, 32'h55AA_55AA);
    check("t3_mem_addr", bus.mem_addr, 32'h1001_0010);
    check("t3_rom_err",  bus.wr_rom_err, 0);
    bus.dev_req = 1'b0; bus.dev_we = 1'b0;
    step();
    check("t3_we_off",   bus.mem_we,     0);
    check("t3_no_rv",    bus.dev_rvalid, 0);
    check("t3_gnt_off",  bus.dev_gnt,    0);

    // 4: core write to ROM is dropped
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0040_0000; bus.cpu_wdata = 32'h1234_5678;
    step();
    check("t4_cpu_gnt",  bus.cpu_gnt,    1);
    check("t4_mem_we",   bus.mem_we,     0);
    check("t4_rom_err",  bus.wr_rom_err, 1);
    check("t4_mem_sel",  bus.mem_sel,    0);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    step();
    check("t4_err_off",  bus.wr_rom_err, 0);
    check("t4_gnt_off",  bus.cpu_gnt,    0);
    check("t4_no_rv",    bus.cpu_rvalid, 0);
    check("t4_data_hold", bus.mem_data,  32'h1234_5678);

    // 5: back-to-back core reads with request held high
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1001_0020;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5_gnt%0d", i),    bus.cpu_gnt,    1);
      check($sformatf("t5_rv_lo%0d", i),  bus.cpu_rvalid, 0);
      step();
      check($sformatf("t5_gnt_lo%0d", i), bus.cpu_gnt,    0);
      check($sformatf("t5_rv%0d", i),     bus.cpu_rvalid, 1);
      check($sformatf("t5_rdata%0d", i),  bus.rdata,      mem_model(32'h1001_0020));
      if (i == 2) bus.cpu_req = 1'b0;
    end

    // 6: device read interrupted by reset during RESP, then a tie
    bus.dev_req = 1'b1; bus.dev_we = 1'b0; bus.dev_addr = 32'h1001_0300;
    step();
    check("t6_dev_gnt", bus.dev_gnt, 1);
    step();
    check("t6_dev_rv",  bus.dev_rvalid, 1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_rv",    bus.dev_rvalid, 0);
    check("t6_rst_rdata", bus.rdata,      0);
    check("t6_rst_addr",  bus.mem_addr,   0);
    check("t6_rst_data",  bus.mem_data,   0);
    check("t6_rst_sel",   bus.mem_sel,    0);
    check("t6_rst_we",    bus.mem_we,     0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1001_0400;
    step();
    reset = 1'b0;
    step();
    check("t6_tie_cpu", bus.cpu_gnt, 1);
    check("t6_tie_dev", bus.dev_gnt, 0);
    bus.cpu_req = 1'b0;
    bus.dev_req = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
